// File: rtl/mips_ctrl_fsm.sv
// mips_ctrl_fsm: multi-cycle control sequencer for the non-pipelined MIPS core.
// Optional overflow trap state: define MIPS_CTRL_OVF_TRAP_EN.
package ALU_pkg;
  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_MUL
  } ALU_ctrl_e;
endpackage

module mips_ctrl_fsm
  import ALU_pkg::*;
#(
  parameter int ALU_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero_f,
  input  logic       overflow_f,
  input  logic       mem_rdy,
  output logic       mem_re,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output ALU_ctrl_e  alu_ctrl,
  output logic       alu_en,
  output logic       aluout_we,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal,
  output logic       exc
);

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXEC,
    RWB,
    BRANCH,
    ADDIEX,
    ADDIWB,
`ifdef MIPS_CTRL_OVF_TRAP_EN
    TRAP,
`endif
    JUMP
  } state_e;

  localparam logic [1:0] LAT = 2'(ALU_LAT);

  state_e     state_q, state_d;
  logic [1:0] lat_q;
  logic       done;
  logic       fn_ok;
  ALU_ctrl_e  fn_op;

  assign done = (lat_q == 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      lat_q   <= LAT;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        lat_q <= LAT;
      else if (!done)
        lat_q <= lat_q - 2'd1;
    end
  end

`ifdef MIPS_CTRL_OVF_TRAP_EN
  logic ovf_q;

  // Only ADD/SUB/ADDI can raise a trappable overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_q <= 1'b0;
    else if (done && state_q == EXEC)
      ovf_q <= overflow_f &&
               (fn_op == ALU_ADD || fn_op == ALU_SUB);
    else if (done && state_q == ADDIEX)
      ovf_q <= overflow_f;
  end
`else
  logic unused_ovf;
  assign unused_ovf = overflow_f;
`endif

  always_comb begin
    fn_ok = 1'b1;
    fn_op = ALU_ADD;
    unique case (funct)
      6'h20:   fn_op = ALU_ADD;
      6'h22:   fn_op = ALU_SUB;
      6'h24:   fn_op = ALU_AND;
      6'h25:   fn_op = ALU_OR;
      6'h26:   fn_op = ALU_XOR;
      6'h18:   fn_op = ALU_MUL;
      default: fn_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctrl   = ALU_ADD;
    alu_en     = 1'b0;
    aluout_we  = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    exc        = 1'b0;
    unique case (state_q)
      FETCH: begin
        mem_re    = 1'b1;
        alu_src_b = 2'b01;
        alu_en    = 1'b1;
        if (done && mem_rdy) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        alu_src_b = 2'b11;
        alu_en    = 1'b1;
        if (done) begin
          aluout_we = 1'b1;
          unique case (1'b1)
            (opcode == 6'h00 && fn_ok):
              state_d = EXEC;
            (opcode == 6'h23 || opcode == 6'h2B):
              state_d = MEMADR;
            (opcode == 6'h04): state_d = BRANCH;
            (opcode == 6'h08): state_d = ADDIEX;
            (opcode == 6'h02): state_d = JUMP;
            default: begin
              illegal = 1'b1;
              state_d = FETCH;
            end
          endcase
        end
      end
      MEMADR, ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_en    = 1'b1;
        if (done) begin
          aluout_we = 1'b1;
          if (state_q == ADDIEX)
            state_d = ADDIWB;
          else if (opcode == 6'h23)
            state_d = MEMREAD;
          else
            state_d = MEMWRITE;
        end
      end
      MEMREAD: begin
        mem_re = 1'b1;
        iord   = 1'b1;
        if (mem_rdy) state_d = MEMWB;
      end
      MEMWB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = FETCH;
      end
      MEMWRITE: begin
        mem_we = 1'b1;
        iord   = 1'b1;
        if (mem_rdy) state_d = FETCH;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_ctrl  = fn_op;
        alu_en    = 1'b1;
        if (done) begin
          aluout_we = 1'b1;
          state_d   = RWB;
        end
      end
      RWB, ADDIWB: begin
        reg_dst = (state_q == RWB);
        state_d = FETCH;
`ifdef MIPS_CTRL_OVF_TRAP_EN
        if (ovf_q) state_d = TRAP;
        else reg_we = 1'b1;
`else
        reg_we = 1'b1;
`endif
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = ALU_SUB;
        alu_en    = 1'b1;
        if (done) begin
          pc_src  = 2'b01;
          pc_we   = zero_f;
          state_d = FETCH;
        end
      end
      JUMP: begin
        pc_src  = 2'b10;
        pc_we   = 1'b1;
        state_d = FETCH;
      end
`ifdef MIPS_CTRL_OVF_TRAP_EN
      TRAP: exc = 1'b1;
`endif
      default: state_d = FETCH;
    endcase
  end

endmodule

// File: doc/mips_ctrl_fsm.md
# mips_ctrl_fsm

Multi-cycle control unit for the non-pipelined MIPS core. It decodes the instruction opcode and function fields, sequences the FETCH/DECODE/EXECUTE/MEM/WB states, and drives the ALU's `ctrl` and `en` inputs plus all datapath mux selects and write enables. It sits directly upstream of the ALU and stretches each ALU-using state to cover the ALU's register latency.

## Interface

**Parameters**
- `ALU_LAT`, default 2, number of enabled clock edges from ALU operand presentation to valid `Result`/flags. Equals REG_INPUTS + REG_OUTPUTS of the ALU instance; legal range 0..3.

**Ports**
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: instruction register bits [31:26].
- `funct` in 6: instruction register bits [5:0].
- `zero_f` in 1: ALU zero flag.
- `overflow_f` in 1: ALU overflow flag.
- `mem_rdy` in 1: memory completes the current read or write this cycle.
- `mem_re` out 1: memory read request.
- `mem_we` out 1: memory write request.
- `iord` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `ir_we` out 1: instruction register load.
- `pc_we` out 1: PC load.
- `pc_src` out 2: PC source, 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_src_a` out 1: ALU A select, 0 = PC, 1 = register A (rs).
- `alu_src_b` out 2: ALU B select, 00 = register B (rt), 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- `alu_ctrl` out ALU_ctrl_e: ALU operation (from ALU_pkg).
- `alu_en` out 1: ALU register enable.
- `aluout_we` out 1: ALUOut register load.
- `reg_we` out 1: register file write.
- `reg_dst` out 1: destination select, 0 = rt, 1 = rd.
- `mem_to_reg` out 1: writeback select, 0 = ALUOut, 1 = MDR.
- `illegal` out 1: one-cycle pulse on an unsupported opcode or funct.
- `exc` out 1: overflow trap indicator.

## Operation

- **State register.** The states are FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC, RWB, BRANCH, ADDIEX, ADDIWB, JUMP, TRAP.
- **Outputs.** All outputs are Moore-decoded from the state, except the completion-cycle strobes (`ir_we`, `pc_we`, `aluout_we`), which also depend on `lat_cnt` and `mem_rdy`. Any output not listed for a state is 0.
- **Latency counter.** On entry to an ALU state, `lat_cnt` loads `ALU_LAT`.
  - While `lat_cnt` != 0: `alu_en` = 1, selects and `alu_ctrl` are held stable, and `lat_cnt` decrements.
  - The state completes in the cycle where `lat_cnt` == 0. `alu_en` stays 1 in that cycle.
- **FETCH**: `mem_re` = 1, `iord` = 0, A = PC, B = 4, ADD.
  - Completes when `lat_cnt` == 0 and `mem_rdy` = 1.
  - On completion: `ir_we` = 1, `pc_we` = 1, `pc_src` = 00, then go to DECODE.
- **DECODE**: A = PC, B = 11, ADD. On completion `aluout_we` = 1, then dispatch on `opcode`:
  - 0x00 → EXEC, if funct is supported.
  - 0x23 or 0x2B → MEMADR.
  - 0x04 → BRANCH.
  - 0x08 → ADDIEX.
  - 0x02 → JUMP.
  - Anything else: `illegal` = 1 and go to FETCH.
- **funct decode**: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x18 MUL (low word kept). Any other funct is illegal.
- **MEMADR**: A = rs, B = 10, ADD. On completion `aluout_we` = 1, then go to MEMREAD (lw) or MEMWRITE (sw).
- **MEMREAD**: `mem_re` = 1, `iord` = 1. Stays until `mem_rdy`, then goes to MEMWB.
- **MEMWB**: `reg_we` = 1, `reg_dst` = 0, `mem_to_reg` = 1, then go to FETCH.
- **MEMWRITE**: `mem_we` = 1, `iord` = 1. Stays until `mem_rdy`, then goes to FETCH.
- **EXEC**: A = rs, B = 00, decoded op. On completion `aluout_we` = 1, then go to RWB.
- **RWB**: `reg_we` = 1, `reg_dst` = 1, then go to FETCH.
- **ADDIEX**: A = rs, B = 10, ADD. On completion `aluout_we` = 1, then go to ADDIWB.
- **ADDIWB**: `reg_we` = 1, `reg_dst` = 0, then go to FETCH.
- **BRANCH**: A = rs, B = 00, SUB. On completion `pc_src` = 01 and `pc_we` = `zero_f`, then go to FETCH.
- **JUMP**: `pc_src` = 10, `pc_we` = 1, then go to FETCH.

## Timing

- **Reset.** Asynchronous assertion forces state = FETCH, `lat_cnt` = `ALU_LAT`, and clears the overflow capture flag.
  - Resulting output values: `mem_re` = 1, `alu_en` = 1, `alu_src_b` = 01, `alu_ctrl` = ADD; all other outputs 0.
  - Reset asserted mid-instruction abandons it; no write enable is issued.
- **Cycle counts**, with memory ready immediately:
  - FETCH and DECODE take `ALU_LAT`+1 cycles each.
  - JUMP takes 1 cycle.
  - R-type total = 3·(`ALU_LAT`+1) + 1.
- **FETCH handshake.** If `mem_rdy` arrives before `lat_cnt` reaches 0, the FSM waits for the counter. If the counter expires first, the FSM holds with `alu_en` = 1.
- **Memory requests.** `mem_re` and `mem_we` stay asserted until the `mem_rdy` cycle, inclusive.
- **Overflow capture.** `overflow_f` is sampled only in the completion cycle of EXEC (ADD or SUB only) and ADDIEX.

## Configuration

- **`MIPS_CTRL_OVF_TRAP_EN` defined:**
  - A captured overflow makes RWB or ADDIWB go to TRAP instead, with `reg_we` = 0.
  - In TRAP, `exc` = 1 and all other outputs are 0; the FSM stays in TRAP until `rst_n` asserts.
- **Undefined:** overflow is ignored, `exc` is tied to 0, and the TRAP state is not built.

## Test plan

- **Reset then add.** `ALU_LAT` = 2, `mem_rdy` = 1, reset, then opcode 0x00 / funct 0x20 → `reg_we` = 1 with `reg_dst` = 1 in cycle 10 after reset release; `alu_ctrl` = ADD during EXEC.
- **lw with memory wait.** lw, `mem_rdy` held low for 3 cycles in MEMREAD → `mem_re` stays 1 for 4 cycles, then MEMWB pulses `reg_we` with `mem_to_reg` = 1.
- **beq, both outcomes.** beq with `zero_f` = 1 → `pc_we` = 1, `pc_src` = 01, `alu_ctrl` = SUB. Same instruction with `zero_f` = 0 → `pc_we` = 0.
- **Illegal decode.** opcode 0x3F, and separately funct 0x27 → `illegal` pulses for one cycle and the next cycle is FETCH.
- **Overflow trap.** With the macro defined: ADD with `overflow_f` = 1 at EXEC completion → `exc` = 1 and `reg_we` never asserts. Without the macro → RWB writes normally.
- **Reset mid-operation.** `ALU_LAT` = 0 gives single-cycle ALU states. Reset asserted during MEMWRITE → `mem_we` drops asynchronously and the FSM restarts in FETCH.
